// File: rtl/interval_meter.sv
// interval_meter: counts the clock cycles between successive event marks and hands the result over a valid/ready pair.
// Define INTERVAL_METER_OVERRUN_EN to add the sticky 'overrun' output; the event mark input is named evt because event is a reserved word.
module interval_meter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         evt,
  input  logic         stop,
  input  logic         ready,
  output logic         busy,
  output logic [W-1:0] value,
  output logic         ovf,
  output logic         valid
`ifdef INTERVAL_METER_OVERRUN_EN
  ,
  output logic         overrun
`endif
);

  localparam logic [0:0]   IDLE    = 1'b0;
  localparam logic [0:0]   RUN     = 1'b1;
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [0:0]   state_r, state_s;
  logic [W-1:0] cnt_r, cnt_s;
  logic         sat_r, sat_s;
  logic         capture_s;
  logic         load_s;
  logic [W-1:0] value_r;
  logic         ovf_r;
  logic         valid_r;

  // Next-state for the measurement FSM; stop outranks any event.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    sat_s     = sat_r;
    capture_s = 1'b0;
    if (stop) begin
      state_s = IDLE;
      cnt_s   = '0;
      sat_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (evt) begin
            state_s = RUN;
            cnt_s   = CNT_ONE;
            sat_s   = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (evt) begin
            capture_s = 1'b1;
            cnt_s     = CNT_ONE;
            sat_s     = 1'b0;
          end else if (cnt_r != CNT_MAX) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            sat_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
          sat_s   = 1'b0;
        end
      endcase
    end
  end

  // A capture only lands when the output slot is free or being emptied this edge.
  assign load_s = capture_s && (!valid_r || ready);

  // Measurement state and result holding registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      sat_r   <= 1'b0;
      value_r <= '0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sat_r   <= sat_s;
      if (load_s) begin
        value_r <= cnt_r;
        ovf_r   <= sat_r;
        valid_r <= 1'b1;
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign busy  = state_r[0];
  assign value = value_r;
  assign ovf   = ovf_r;
  assign valid = valid_r;

`ifdef INTERVAL_METER_OVERRUN_EN
  logic drop_s;
  logic overrun_r;

  assign drop_s = capture_s && valid_r && !ready;

  // Sticky record of a result lost to a full output slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_r <= 1'b0;
    end else if (stop) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign overrun = overrun_r;
`endif

endmodule

// File: tb/tb_interval_meter.sv
// Directed self-checking bench for interval_meter (W=8); overrun checks compile in with INTERVAL_METER_OVERRUN_EN.
module tb_interval_meter;

  logic       clock = 1'b0;
  logic       reset;
  logic       evt;
  logic       stop;
  logic       ready;
  logic       busy;
  logic [7:0] value;
  logic       ovf;
  logic       valid;
`ifdef INTERVAL_METER_OVERRUN_EN
  logic       overrun;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  interval_meter #(.W(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .evt    (evt),
    .stop   (stop),
    .ready  (ready),
    .busy   (busy),
    .value  (value),
    .ovf    (ovf),
    .valid  (valid)
`ifdef INTERVAL_METER_OVERRUN_EN
    ,
    .overrun(overrun)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Close an interval of n cycles measured from the previous event edge.
  task automatic interval(input int n);
    repeat (n - 1) tick();
    evt = 1'b1;
    tick();
    evt = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    evt   = 1'b0;
    stop  = 1'b0;
    ready = 1'b1;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_value", value, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b1;

    // Basic 5-cycle interval
    evt = 1'b1; tick(); evt = 1'b0;
    check("start_busy", busy, 1);
    check("start_valid", valid, 0);
    repeat (4) tick();
    check("run_valid", valid, 0);
    evt = 1'b1; tick(); evt = 1'b0;
    check("i5_valid", valid, 1);
    check("i5_value", value, 5);
    check("i5_ovf", ovf, 0);
    tick();
    check("i5_consumed", valid, 0);

    // Saturation boundaries
    do_stop();
    check("stop_busy", busy, 0);
    evt = 1'b1; tick(); evt = 1'b0;
    interval(255);
    check("i255_value", value, 255);
    check("i255_ovf", ovf, 0);
    interval(256);
    check("i256_value", value, 255);
    check("i256_ovf", ovf, 1);
    interval(300);
    check("i300_value", value, 255);
    check("i300_ovf", ovf, 1);
    interval(1);
    check("i1_value", value, 1);
    check("i1_ovf", ovf, 0);
    check("i1_valid", valid, 1);

    // Back-to-back events with ready held high
    do_stop();
    check("b2b_pre_valid", valid, 0);
    evt = 1'b1;
    tick();
    check("b2b_start_valid", valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("b2b_valid", valid, 1);
      check("b2b_value", value, 1);
    end
    evt = 1'b0;
    tick();
    check("b2b_end_valid", valid, 0);

    // Drop while the consumer stalls
    do_stop();
    ready = 1'b0;
    evt = 1'b1; tick(); evt = 1'b0;
    interval(4);
    check("hold_value", value, 4);
    check("hold_valid", valid, 1);
    interval(3);
    check("drop_value", value, 4);
    check("drop_valid", valid, 1);
`ifdef INTERVAL_METER_OVERRUN_EN
    check("drop_overrun", overrun, 1);
`endif
    repeat (3) tick();
    check("stall_value", value, 4);
    check("stall_valid", valid, 1);
    ready = 1'b1;
    tick();
    check("release_valid", valid, 0);
    evt = 1'b1; tick(); evt = 1'b0;
    check("restart_value", value, 5);
    check("restart_valid", valid, 1);
`ifdef INTERVAL_METER_OVERRUN_EN
    check("sticky_overrun", overrun, 1);
`endif
    do_stop();
`ifdef INTERVAL_METER_OVERRUN_EN
    check("stop_clr_overrun", overrun, 0);
`endif
    check("stop2_busy", busy, 0);

    // stop leaves a pending result intact
    ready = 1'b0;
    evt = 1'b1; tick(); evt = 1'b0;
    interval(3);
    check("pend_value", value, 3);
    stop = 1'b1; evt = 1'b1; tick(); stop = 1'b0; evt = 1'b0;
    check("pend_busy", busy, 0);
    check("pend_valid", valid, 1);
    check("pend_keep_value", value, 3);
    ready = 1'b1;
    tick();
    check("pend_consumed", valid, 0);

    // stop beats a simultaneous closing event
    evt = 1'b1; tick(); evt = 1'b0;
    repeat (5) tick();
    stop = 1'b1; evt = 1'b1; tick(); stop = 1'b0; evt = 1'b0;
    check("prio_busy", busy, 0);
    check("prio_valid", valid, 0);
    repeat (2) tick();
    evt = 1'b1; tick(); evt = 1'b0;
    check("prio_restart_busy", busy, 1);
    check("prio_restart_valid", valid, 0);

    // Asynchronous reset mid-measurement with a pending result
    ready = 1'b0;
    interval(2);
    check("pre_rst_value", value, 2);
    check("pre_rst_valid", valid, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    check("arst_value", value, 0);
    check("arst_ovf", ovf, 0);
    #2 reset = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    evt = 1'b1; tick(); evt = 1'b0;
    check("post_rst_first_busy", busy, 1);
    check("post_rst_first_valid", valid, 0);
    interval(3);
    check("post_rst_value", value, 3);
    check("post_rst_valid", valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/interval_meter.md
INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001 SHALL have parameter W, default 8, giving the width of the measured interval in clock cycles.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port event  input  1  single-cycle mark; each sampled high marks an interval boundary.
REQ-005 SHALL have port stop  input  1  abort measurement and return to idle.
REQ-006 SHALL have port busy  output  1  high while a measurement is running.
REQ-007 SHALL have port value  output  W  last captured interval length in cycles.
REQ-008 SHALL have port ovf  output  1  captured interval exceeded 2^W-1; qualified by valid.
REQ-009 SHALL have port valid  output  1  value/ovf hold an unconsumed result.
REQ-010 SHALL have port ready  input  1  consumer accepts the result when valid && ready.

Function
REQ-011 SHALL implement two states: IDLE (busy=0) and RUN (busy=1), with an internal W-bit counter cnt and a saturation flag sat.
REQ-012 IDLE, event=1, stop=0: go to RUN, cnt<=1, sat<=0; no result produced.
REQ-013 RUN, event=0, stop=0: cnt<=cnt+1 if cnt<2^W-1; else cnt unchanged and sat<=1.
REQ-014 RUN, event=1, stop=0: capture value<=cnt, ovf<=sat, then cnt<=1, sat<=0, stay in RUN; events at edges t0 and t1 therefore yield value=t1-t0.
REQ-015 Back-to-back events (t1=t0+1) SHALL yield value=1, ovf=0.
REQ-016 Interval of exactly 2^W-1 SHALL yield value=2^W-1, ovf=0; any longer interval yields value=2^W-1, ovf=1.
REQ-017 A capture SHALL set valid<=1 on the same edge; results appear one cycle after the closing event.
REQ-018 valid SHALL stay high with value/ovf stable until a cycle with valid && ready; then valid<=0 unless a capture occurs on that same edge.
REQ-019 Capture while valid && ready: new result loads and valid remains 1 (no bubble).
REQ-020 Capture while valid && !ready: new result SHALL be dropped; held value/ovf unchanged; cnt restarts per REQ-014 regardless.
REQ-021 stop=1 in any state: go to IDLE, cnt<=0, sat<=0; stop has priority over a simultaneous event (no capture).
REQ-022 stop SHALL NOT affect valid, value or ovf; a pending result remains consumable.

Reset
REQ-023 While reset=0, asynchronously: state=IDLE, cnt=0, sat=0, busy=0, valid=0, value=0, ovf=0 (and overrun=0 when compiled in).
REQ-024 Reset asserted mid-measurement SHALL discard the running interval and any pending result.
REQ-025 After reset deasserts, the first event SHALL only start a measurement, never produce a result.

Configuration
REQ-026 Macro INTERVAL_METER_OVERRUN_EN defined: add port overrun  output  1, sticky, set on any drop per REQ-020, cleared only by stop or reset.
REQ-027 Macro undefined: no overrun port and no related logic; drops per REQ-020 are silent; all other behaviour identical.

Verification
REQ-028 W=8, ready=1: events at cycles 10 and 15 -> cycle 16 valid=1, value=5, ovf=0; busy=1 from cycle 11.
REQ-029 W=8: events at 0 and 255 -> value=255, ovf=0; events at 300 and 600 -> value=255, ovf=1.
REQ-030 W=8, ready=0: events at 0, 4, 7 -> value=4 held; second result dropped; overrun=1 (macro on); ready=1 at cycle 20 -> valid=0 at 21.
REQ-031 ready=1 constantly, events at 0,1,2,3 -> valid high cycles 2..4, values 1,1,1, no gap.
REQ-032 events at 0 and 6 with stop=1 at cycle 6 -> no capture, busy=0 at 7; next event at 9 only restarts (no result).
REQ-033 reset=0 at cycle 3 during RUN with valid=1 -> busy, valid, value, ovf immediately 0 without a clock edge.
